clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen.sv | 112 +++++++++++
 tb/tb_clk_en_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Phase-accumulator clock-enable generator: NUM_CH fractional-rate enable channels gated by PLL lock qualification.
// Define CLK_EN_GEN_PHASE_EN to add the half-period-shifted cen_180 outputs; otherwise cen_180 is tied to zero.

module clk_en_gen_lane #(
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 flush,
    input  logic                 wr,
    input  logic                 clr,
    input  logic [ACC_WIDTH-1:0] wr_inc,
    output logic                 cen,
    output logic                 cen_180
);
    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic                 wr_clr;

    assign sum    = {1'b0, acc} + {1'b0, inc};
    assign wr_clr = wr && clr;

    // The add in a write cycle still uses the old increment, so its carry is kept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inc <= '0;
            acc <= '0;
            cen <= 1'b0;
        end else begin
            if (wr)
                inc <= wr_inc;
            if (flush || wr_clr)
                acc <= '0;
            else if (run)
                acc <= sum[ACC_WIDTH-1:0];
            cen <= run && sum[ACC_WIDTH] && !wr_clr;
        end
    end

`ifdef CLK_EN_GEN_PHASE_EN
    // Half-range crossing detected on the add itself, so it lines up with cen timing.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cen_180 <= 1'b0;
        else
            cen_180 <= run && !wr_clr && !acc[ACC_WIDTH-1] && sum[ACC_WIDTH-1];
    end
`else
    assign cen_180 = 1'b0;
`endif
endmodule

module clk_en_gen #(
    parameter int NUM_CH     = 2,
    parameter int ACC_WIDTH  = 16,
    parameter int LOCK_DELAY = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 locked,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    input  logic                 cfg_clr,
    output logic [NUM_CH-1:0]    cen,
    output logic [NUM_CH-1:0]    cen_180,
    output logic                 ready
);
    localparam int LCNT_W = $clog2(LOCK_DELAY + 1);

    logic [LCNT_W-1:0] lock_cnt;
    logic [NUM_CH-1:0] wr_sel;
    logic              run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            ready    <= 1'b0;
        end else if (!locked) begin
            lock_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            if (lock_cnt != LCNT_W'(LOCK_DELAY))
                lock_cnt <= lock_cnt + LCNT_W'(1);
            ready <= (lock_cnt == LCNT_W'(LOCK_DELAY));
        end
    end

    // A locked=0 cycle must not advance the accumulators even while ready is still high.
    assign run = ready && locked;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign wr_sel[i] = cfg_we && (cfg_ch == CH_W'(i));

        clk_en_gen_lane #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .run    (run),
            .flush  (!locked),
            .wr     (wr_sel[i]),
            .clr    (cfg_clr),
            .wr_inc (cfg_inc),
            .cen    (cen[i]),
            .cen_180(cen_180[i])
        );
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: lock qualification, rates, phase output, re-programming and boundaries.
// Uses NUM_CH=3 so that cfg_ch=3 is representable and out of range.

module tb_clk_en_gen;
    localparam int NUM_CH = 3;
    localparam int AW     = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              locked;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [AW-1:0]     cfg_inc;
    logic              cfg_clr;
    logic [NUM_CH-1:0] cen;
    logic [NUM_CH-1:0] cen_180;
    logic              ready;

    int n_chk = 0;
    int n_err = 0;

    clk_en_gen #(
        .NUM_CH    (NUM_CH),
        .ACC_WIDTH (AW),
        .LOCK_DELAY(16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .locked (locked),
        .cfg_we (cfg_we),
        .cfg_ch (cfg_ch),
        .cfg_inc(cfg_inc),
        .cfg_clr(cfg_clr),
        .cen    (cen),
        .cen_180(cen_180),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One rising edge; returns on the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [AW-1:0] inc, input logic clr);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_inc = inc;
        cfg_clr = clr;
        step();
        cfg_we  = 1'b0;
        cfg_clr = 1'b0;
    endtask

    // Counts cen[ch] pulses over n edges and how many pulse gaps differ from gap.
    task automatic measure(input int ch, input int n, input int gap, output int cnt, output int bad);
        int last;
        last = -1;
        cnt  = 0;
        bad  = 0;
        for (int t = 1; t <= n; t++) begin
            step();
            if (cen[ch]) begin
                cnt++;
                if (last >= 0 && (t - last) != gap)
                    bad++;
                last = t;
            end
        end
    endtask

    initial begin
        int cnt, bad, k, p1, p2;
        logic [40:1] c_rec, h_rec;

        rst_n = 1'b0; locked = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_clr = 1'b0;
        @(negedge clk);
        step(); step();
        chk("rst_ready", ready, 0);
        chk("rst_cen", cen, 0);
        chk("rst_cen180", cen_180, 0);

        // Increment written out of reset must be wiped by a later reset.
        rst_n = 1'b1;
        wr(0, 16'h8000, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        locked = 1'b1;
        repeat (16) step();
        chk("lock_early", ready, 0);
        step();
        chk("lock_rise", ready, 1);
        measure(0, 10, 2, cnt, bad);
        chk("rst_inc_cleared", cnt, 0);

        locked = 1'b0;
        step();
        chk("lock_drop", ready, 0);
        locked = 1'b1;
        repeat (16) step();
        chk("relock_early", ready, 0);
        step();
        chk("relock_rise", ready, 1);

        wr(0, 16'h8000, 1'b1);
        wr(1, 16'h1000, 1'b1);
        measure(0, 64, 2, cnt, bad);
        chk("rate0_cnt", cnt, 32);
        chk("rate0_gap", bad, 0);
        measure(1, 64, 16, cnt, bad);
        chk("rate1_cnt", cnt, 4);
        chk("rate1_gap", bad, 0);

        wr(2, 16'h4000, 1'b1);
        for (int t = 1; t <= 40; t++) begin
            step();
            c_rec[t] = cen[2];
            h_rec[t] = cen_180[2];
        end
        chk("phase_cen_cnt", $countones(c_rec), 10);
`ifdef CLK_EN_GEN_PHASE_EN
        chk("phase_180_cnt", $countones(h_rec), 10);
        bad = 0;
        for (int t = 1; t <= 38; t++)
            if (c_rec[t] && !h_rec[t+2]) bad++;
        chk("phase_180_lag", bad, 0);
        chk("phase_180_first", h_rec[2], 1);
`else
        chk("phase_180_off", $countones(h_rec), 0);
`endif

        // Re-program on an overflow cycle of inc=0x8000.
        k = 0;
        while (!cen[0] && k < 20) begin
            step();
            k++;
        end
        chk("find_pulse0", cen[0], 1);
        step();
        wr(0, 16'h2000, 1'b0);
        chk("old_inc_pulse", cen[0], 1);
        p1 = 0; p2 = 0;
        for (int t = 1; t <= 16; t++) begin
            step();
            if (cen[0]) begin
                if (p1 == 0) p1 = t;
                else if (p2 == 0) p2 = t;
            end
        end
        chk("new_inc_p1", p1, 8);
        chk("new_inc_p2", p2, 16);

        // Clear on what would be an overflow cycle: carry suppressed, next pulse 8 later.
        repeat (7) step();
        wr(0, 16'h2000, 1'b1);
        chk("clr_suppress", cen[0], 0);
        p1 = 0;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (cen[0] && p1 == 0) p1 = t;
        end
        chk("clr_next_pulse", p1, 8);

        wr(1, 16'h0000, 1'b0);
        measure(1, 40, 1, cnt, bad);
        chk("inc0_none", cnt, 0);
        wr(3, 16'h8000, 1'b1);
        measure(2, 40, 4, cnt, bad);
        chk("ch3_ch2_cnt", cnt, 10);
        chk("ch3_ch2_gap", bad, 0);
        measure(1, 40, 1, cnt, bad);
        chk("ch3_ch1_none", cnt, 0);

        // Lock loss clears accumulators but keeps increments.
        locked = 1'b0;
        step();
        chk("loss_ready", ready, 0);
        chk("loss_cen", cen, 0);
        chk("loss_cen180", cen_180, 0);
        locked = 1'b1;
        repeat (20) step();
        chk("retain_pre", cen[2], 0);
        step();
        chk("retain_first", cen[2], 1);

        wr(1, 16'hFFFF, 1'b1);
        measure(1, 65536, 1, cnt, bad);
        chk("ffff_cnt", cnt, 65535);
        chk("ffff_gap", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
